// File: rtl/vadd_cmd_dispatch.sv
// Vector-add command dispatcher.
// Queues host commands in a small FIFO, launches them one at a time into the
// vector-add compute FSM, holds operands for the whole run and returns a
// tagged completion record. Zero-length commands complete without a launch.
module vadd_cmd_dispatch #(
    parameter int ADDR_WIDTH = 13,
    parameter int LEN_WIDTH  = 23,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_out,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [TAG_WIDTH-1:0]  cmd_tag,
    output logic                  start,
    output logic [ADDR_WIDTH-1:0] addr_a_vadd,
    output logic [ADDR_WIDTH-1:0] addr_b_vadd,
    output logic [ADDR_WIDTH-1:0] addr_out_vadd,
    output logic [LEN_WIDTH-1:0]  len_vadd,
    input  logic                  compute_done,
    output logic                  cpl_valid,
    input  logic                  cpl_ready,
    output logic [TAG_WIDTH-1:0]  cpl_tag,
    output logic [1:0]            cpl_status,
    output logic                  busy,
    output logic [15:0]           done_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 3 * ADDR_WIDTH + LEN_WIDTH + TAG_WIDTH;

    localparam logic [1:0] STATUS_EXEC = 2'd0;
    localparam logic [1:0] STATUS_SKIP = 2'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  cpl_hs;
    logic                  retire;
    logic [ENT_W-1:0]      head;
    logic [ADDR_WIDTH-1:0] head_a;
    logic [ADDR_WIDTH-1:0] head_b;
    logic [ADDR_WIDTH-1:0] head_out;
    logic [LEN_WIDTH-1:0]  head_len;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic                  head_zero;
    logic [TAG_WIDTH-1:0]  run_tag;

    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    // The cycle right after a completion handshake is a settle cycle: the
    // compute FSM gets one idle cycle before the next launch.
    assign pop        = (state == IDLE) && !fifo_empty && !retire;
    assign cpl_hs     = (state == REPORT) && cpl_ready;

    assign head = fifo_mem[rd_ptr];
    assign {head_a, head_b, head_out, head_len, head_tag} = head;
    assign head_zero = (head_len == '0);

    assign start     = (state == LAUNCH);
    assign cpl_valid = (state == REPORT);
    assign busy      = (state != IDLE) || !fifo_empty;

    // Command storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_addr_a, cmd_addr_b, cmd_addr_out, cmd_len, cmd_tag};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // State register plus the one-cycle post-handshake settle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            retire <= 1'b0;
        end else begin
            state  <= state_nxt;
            retire <= cpl_hs;
        end
    end

    // Next-state logic; compute_done only matters while a run is in flight.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = head_zero ? REPORT : LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (compute_done) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (cpl_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand hold registers; loaded only when a non-zero command is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a_vadd   <= '0;
            addr_b_vadd   <= '0;
            addr_out_vadd <= '0;
            len_vadd      <= '0;
        end else if (pop && !head_zero) begin
            addr_a_vadd   <= head_a;
            addr_b_vadd   <= head_b;
            addr_out_vadd <= head_out;
            len_vadd      <= head_len;
        end
    end

    // Tag of the command currently in flight, echoed at completion.
    always_ff @(posedge clk) begin
        if (pop) begin
            run_tag <= head_tag;
        end
    end

    // Completion record: skipped commands report immediately, executed ones on done.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpl_tag    <= '0;
            cpl_status <= STATUS_EXEC;
        end else if (pop && head_zero) begin
            cpl_tag    <= head_tag;
            cpl_status <= STATUS_SKIP;
        end else if ((state == RUN) && compute_done) begin
            cpl_tag    <= run_tag;
            cpl_status <= STATUS_EXEC;
        end
    end

    // Completed-command counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_count <= '0;
        end else if (cpl_hs) begin
            done_count <= done_count + 16'd1;
        end
    end

endmodule

// File: doc/vadd_cmd_dispatch.md
Name: vadd_cmd_dispatch

Overview:
Command front-end sitting directly upstream of the vector-add compute FSM; it is the only driver of that FSM's start, addr_a_vadd, addr_b_vadd, addr_out_vadd and len_vadd inputs. It buffers vector-add commands from the host/control path in a small FIFO and launches them one at a time. It holds operands stable for the whole run, waits for the compute FSM's done pulse, and returns a tagged completion record. Zero-length commands are filtered here because the compute FSM must never be started with len = 0.

Parameters:
ADDR_WIDTH, 13, BRAM word-address width (matches compute FSM)
LEN_WIDTH, 23, vector length width (matches compute FSM len_vadd)
TAG_WIDTH, 4, command tag width
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_addr_a  in  ADDR_WIDTH  base of operand A
cmd_addr_b  in  ADDR_WIDTH  base of operand B
cmd_addr_out  in  ADDR_WIDTH  base of result
cmd_len  in  LEN_WIDTH  element count
cmd_tag  in  TAG_WIDTH  opaque id echoed in completion
start  out  1  one-cycle launch pulse to compute FSM
addr_a_vadd  out  ADDR_WIDTH  held operand A base
addr_b_vadd  out  ADDR_WIDTH  held operand B base
addr_out_vadd  out  ADDR_WIDTH  held result base
len_vadd  out  LEN_WIDTH  held length
compute_done  in  1  one-cycle done pulse from compute FSM
cpl_valid  out  1  completion record valid
cpl_ready  in  1  completion consumer ready
cpl_tag  out  TAG_WIDTH  tag of completed command
cpl_status  out  2  0 = executed, 1 = skipped (len = 0), 2..3 reserved (never driven)
busy  out  1  high in any state other than IDLE or when FIFO is non-empty
done_count  out  16  completed commands, wraps at 0xFFFF -> 0

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: FIFO empty, cmd_ready = 1, start = 0, all addr/len outputs = 0, cpl_valid = 0, cpl_tag = 0, cpl_status = 0, busy = 0, done_count = 0, state = IDLE.
- Reset mid-run: FIFO and completion are discarded. The compute FSM shares the reset domain, so no drain is performed.
- FIFO push: occurs when cmd_valid && cmd_ready, storing {addr_a, addr_b, addr_out, len, tag}. cmd_ready depends only on full, not on a same-cycle pop.
- Full/empty: cmd_valid while full is ignored, with no overwrite. Pop while empty cannot occur. Count and pointers wrap modulo FIFO_DEPTH.
- Same-cycle push and pop: both occur; occupancy is unchanged.
- States: IDLE, LAUNCH, RUN, REPORT.
- IDLE, FIFO non-empty: pop the head.
  - If len != 0: register addr/len onto the *_vadd outputs and go to LAUNCH.
  - If len == 0: leave the *_vadd outputs untouched, load cpl_tag, set cpl_status = 1, and go to REPORT.
- LAUNCH: start = 1 for exactly this cycle, then go to RUN.
- RUN: hold all *_vadd outputs constant; the compute FSM re-reads them every element. On compute_done, load cpl_tag, set cpl_status = 0, and go to REPORT.
- compute_done outside RUN: ignored.
- REPORT: cpl_valid = 1 and the record is held stable until cpl_ready. On the handshake, done_count increments, cpl_valid drops the next cycle, and the state returns to IDLE.
- Back-pressure: cpl_ready low stalls the dispatcher in REPORT, and no new launch occurs.
- Latency, non-zero command pushed into an empty FIFO while idle:
  - Push at cycle N; pop in IDLE at N+1.
  - start high at N+2.
  - compute_done at cycle D means cpl_valid is high at D+1.
  - With cpl_ready held high, the next start occurs no earlier than D+4.
- start is never asserted while the state is RUN or REPORT; at most one command is in flight.
- *_vadd outputs change only on an IDLE pop of a non-zero command.

Test Plan:
1. Single command (a=0x010, b=0x020, out=0x030, len=3, tag=5), cpl_ready=1, compute_done pulsed 10 cycles after start -> exactly one start pulse; *_vadd stable from launch through done; cpl_valid one cycle with tag=5, status=0; done_count=1.
2. Push 5 commands back-to-back, FIFO_DEPTH=4, no launch progress -> cmd_ready low after 4 accepted (one popped leaves room for the 5th), no entry lost; completions arrive in push order with tags 0..4.
3. len=0 command with tag=9 -> no start pulse; cpl_valid with tag=9, status=1 at push+2; *_vadd retain their previous values.
4. cpl_ready held low 20 cycles after a completion -> cpl_valid/cpl_tag stable throughout; no second start despite a queued command; release cpl_ready -> next start 3 cycles later.
5. Spurious compute_done in IDLE and LAUNCH -> ignored; no completion generated.
6. rst asserted one cycle during RUN with 2 commands queued -> next cycle all outputs at reset values, FIFO empty, done_count=0; a new command afterwards completes normally.
